pipelined_cla_adder: RTL

Parametrised, pipelined carry-lookahead adder/subtractor, the successor to the 32-bit combinational single-cycle adder in the functional unit. It splits a WIDTH-bit add or subtract into STAGES register slices, each built from GROUP-bit lookahead units. It moves operands and results through valid/ready handshakes so it can sit between the operand-issue stage and the writeback mux under backpressure.

---
 rtl/adder_pkg.sv | 32 +++
 rtl/pipelined_cla_adder_cla_group.sv | 33 +++
 rtl/pipelined_cla_adder.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// Shared types, defaults and configuration check for the pipelined carry-lookahead adder.
package adder_pkg;

   localparam int ADDER_WIDTH     = 32;
   localparam int ADDER_STAGES    = 2;
   localparam int ADDER_GROUP     = 4;
   localparam int ADDER_MAX_WIDTH = 64;

   // Payload carried by each pipeline slice. Operand fields are sized for the widest
   // supported adder; bits above WIDTH stay zero.
   typedef struct packed {
      logic [ADDER_MAX_WIDTH-1:0] a;
      logic [ADDER_MAX_WIDTH-1:0] bx;
      logic [ADDER_MAX_WIDTH-1:0] sum;
      logic                       carry;
      logic                       cmsb;
      logic                       sub;
      logic                       sat;
   } stage_t;

   typedef struct packed {
      logic cout;
      logic ovf;
      logic zero;
   } flags_t;

   function automatic bit adder_cfg_ok(input int width, input int stages, input int group);
      return (stages >= 1) && (stages <= 8) && (group >= 1) && (width >= 1) &&
             (width <= ADDER_MAX_WIDTH) && ((width % (stages * group)) == 0);
   endfunction

endpackage

// File: rtl/pipelined_cla_adder_cla_group.sv
// GROUP-bit lookahead unit: per-bit carries from a group carry-in, plus group propagate/generate.
module cla_group
   import adder_pkg::*;
#(
   parameter int GROUP = ADDER_GROUP
) (
   input  logic [GROUP-1:0] p,
   input  logic [GROUP-1:0] g,
   input  logic             cin,
   output logic [GROUP-1:0] c,
   output logic             pg,
   output logic             gg
);

   // Carry into each bit of the group; c[0] is the group carry-in itself.
   always_comb begin
      c = '0;
      c[0] = cin;
      for (int i = 1; i < GROUP; i++) begin
         c[i] = g[i-1] | (p[i-1] & c[i-1]);
      end
   end

   // Group terms depend only on p/g so the slice-level lookahead can form group carries without a loop.
   always_comb begin
      pg = &p;
      gg = g[0];
      for (int i = 1; i < GROUP; i++) begin
         gg = g[i] | (p[i] & gg);
      end
   end

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined CLA adder/subtractor with valid/ready handshake and one slice per pipeline stage.
// Define ADDER_SAT_EN to add the sat port and signed saturation of the result.
module pipelined_cla_adder
   import adder_pkg::*;
#(
   parameter int WIDTH  = ADDER_WIDTH,
   parameter int STAGES = ADDER_STAGES,
   parameter int GROUP  = ADDER_GROUP
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
`ifdef ADDER_SAT_EN
   input  logic             sat,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int SW = WIDTH / STAGES;
   localparam int NG = SW / GROUP;

   if (!adder_cfg_ok(WIDTH, STAGES, GROUP)) begin : g_cfg_err
      $error("pipelined_cla_adder: WIDTH must be a multiple of STAGES*GROUP and at most ADDER_MAX_WIDTH");
   end

   stage_t [STAGES-1:0] q;
   stage_t [STAGES-1:0] nxt;
   stage_t              head;
   logic   [STAGES-1:0] v;
   logic   [STAGES-1:0] vin;
   logic   [STAGES:0]   rdy;
   logic                unused_q;

   // Subtraction is folded into the operands: a - b - cin == a + ~b + ~cin.
   always_comb begin
      head = '0;
      head.a = ADDER_MAX_WIDTH'(a);
      head.bx = ADDER_MAX_WIDTH'(sub ? ~b : b);
      head.carry = sub ? ~cin : cin;
      head.sub = sub;
`ifdef ADDER_SAT_EN
      head.sat = sat;
`endif
   end

   assign rdy[STAGES] = out_ready;
   assign in_ready = rdy[0];

   for (genvar k = 0; k < STAGES; k++) begin : g_slice
      stage_t          src;
      stage_t          nx;
      logic [SW-1:0]   p;
      logic [SW-1:0]   g;
      logic [SW-1:0]   c;
      logic [NG-1:0]   gp;
      logic [NG-1:0]   gg;
      logic [NG:0]     gc;

      if (k == 0) begin : g_first
         assign src = head;
         assign vin[k] = in_valid;
      end else begin : g_next
         assign src = q[k-1];
         assign vin[k] = v[k-1];
      end

      assign rdy[k] = !v[k] || rdy[k+1];
      assign p = src.a[k*SW +: SW] ^ src.bx[k*SW +: SW];
      assign g = src.a[k*SW +: SW] & src.bx[k*SW +: SW];

      for (genvar j = 0; j < NG; j++) begin : g_group
         cla_group #(.GROUP(GROUP)) u_group (
            .p   (p[j*GROUP +: GROUP]),
            .g   (g[j*GROUP +: GROUP]),
            .cin (gc[j]),
            .c   (c[j*GROUP +: GROUP]),
            .pg  (gp[j]),
            .gg  (gg[j])
         );
      end

      // Second lookahead level: group carries from group propagate/generate.
      always_comb begin
         gc = '0;
         gc[0] = src.carry;
         for (int j = 0; j < NG; j++) begin
            gc[j+1] = gg[j] | (gp[j] & gc[j]);
         end
      end

      always_comb begin
         nx = src;
         nx.sum[k*SW +: SW] = p ^ c;
         nx.carry = gc[NG];
         nx.cmsb = c[SW-1];
      end

      assign nxt[k] = nx;
   end

   // A stage loads whenever it is empty or its contents move on; data only changes on a real beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v <= '0;
         q <= '0;
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (rdy[k]) begin
               v[k] <= vin[k];
               if (vin[k]) begin
                  q[k] <= nxt[k];
               end
            end
         end
      end
   end

   stage_t           last;
   flags_t           flg;
   logic [WIDTH-1:0] res;

`ifdef ADDER_SAT_EN
   localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

   assign last = q[STAGES-1];

   // Overflow only happens when a and bx share a sign, so a's sign picks the clamp direction.
   always_comb begin
      res = last.sum[WIDTH-1:0];
      flg.cout = last.carry;
      flg.ovf = last.cmsb ^ last.carry;
`ifdef ADDER_SAT_EN
      if (last.sat && flg.ovf) begin
         res = last.a[WIDTH-1] ? SAT_MIN : SAT_MAX;
      end
`endif
      flg.zero = (res == '0);
   end

   assign out_valid = v[STAGES-1];
   assign s = res;
   assign cout = flg.cout;
   assign ovf = flg.ovf;
   assign zero = flg.zero;

   assign unused_q = ^q;

endmodule
